hazard_ctrl: RTL and testbench

//  Central stall/flush generator: drives the per-boundary stall_*/flush_* inputs of the

---
 rtl/hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush generator for the pipeline register bank.
// Resolves load-use hazards, taken branches, MEM traps and I/D-cache misses in one
// place. A small FSM remembers the multi-cycle conditions; every pipeline control
// output is combinational from that state plus the current inputs.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_trap,
    input  logic                  icache_miss,
    input  logic                  icache_ready,
    input  logic                  dcache_miss,
    input  logic                  dcache_ready,
    output logic                  pc_stall,
    output logic [1:0]            pc_redirect,
    output logic                  icache_abort,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  stall_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  flush_mem_wb,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    localparam logic [1:0] REDIR_NONE   = 2'b00;
    localparam logic [1:0] REDIR_BRANCH = 2'b01;
    localparam logic [1:0] REDIR_TRAP   = 2'b10;

    // Bit positions inside the boundary vectors (upstream boundary is the MSB).
    localparam int B_IF_ID  = 3;
    localparam int B_ID_EX  = 2;
    localparam int B_EX_MEM = 1;
    localparam int B_MEM_WB = 0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

    logic             rs1_hit, rs2_hit, load_use;
    logic             dmiss_now, fetch_wait;

    logic             pc_stall_raw;
    logic [1:0]       redirect_raw;
    logic             abort_raw;
    logic [3:1]       stall_raw;
    logic [3:0]       flush_raw;

    logic [3:1]       stall_vec;
    logic [3:0]       flush_vec;

    // Load in EX whose destination is read by the instruction in ID; x0 never hazards.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

    // Miss qualifiers: a miss reported together with ready is a hit-after-miss and costs nothing.
    always_comb begin
        dmiss_now  = dcache_miss && !dcache_ready;
        fetch_wait = (state_q == ST_IMISS) ? !icache_ready
                                           : (icache_miss && !icache_ready);
    end

    // Prioritised hazard resolution: D-miss, trap, branch, load-use, I-miss.
    always_comb begin
        state_d      = state_q;
        pc_stall_raw = 1'b0;
        redirect_raw = REDIR_NONE;
        abort_raw    = 1'b0;
        stall_raw    = '0;
        flush_raw    = '0;

        unique case (state_q)
            ST_DMISS: begin
                // Everything else is held by its source while the data refill is pending.
                if (dcache_ready) begin
                    state_d = ST_RUN;
                end else begin
                    pc_stall_raw         = 1'b1;
                    stall_raw[B_IF_ID]   = 1'b1;
                    stall_raw[B_ID_EX]   = 1'b1;
                    stall_raw[B_EX_MEM]  = 1'b1;
                    flush_raw[B_MEM_WB]  = 1'b1;
                end
            end

            ST_TRAP: begin
                // The fetch issued before the redirect took effect must be killed.
                flush_raw[B_IF_ID] = 1'b1;
                state_d            = ST_RUN;
            end

            ST_RUN, ST_IMISS: begin
                if (dmiss_now) begin
                    pc_stall_raw        = 1'b1;
                    stall_raw[B_IF_ID]  = 1'b1;
                    stall_raw[B_ID_EX]  = 1'b1;
                    stall_raw[B_EX_MEM] = 1'b1;
                    flush_raw[B_MEM_WB] = 1'b1;
                    state_d             = ST_DMISS;
                end else if (mem_trap) begin
                    flush_raw[B_IF_ID]  = 1'b1;
                    flush_raw[B_ID_EX]  = 1'b1;
                    flush_raw[B_EX_MEM] = 1'b1;
                    redirect_raw        = REDIR_TRAP;
                    abort_raw           = (state_q == ST_IMISS);
                    state_d             = ST_TRAP;
                end else if (ex_branch_taken) begin
                    flush_raw[B_IF_ID]  = 1'b1;
                    flush_raw[B_ID_EX]  = 1'b1;
                    redirect_raw        = REDIR_BRANCH;
                    abort_raw           = (state_q == ST_IMISS);
                    state_d             = ST_RUN;
                end else begin
                    if (load_use) begin
                        // Keep the ID instruction (no IF/ID flush) and insert one bubble into EX.
                        pc_stall_raw       = 1'b1;
                        stall_raw[B_IF_ID] = 1'b1;
                        flush_raw[B_ID_EX] = 1'b1;
                    end else if (fetch_wait) begin
                        pc_stall_raw       = 1'b1;
                        flush_raw[B_IF_ID] = 1'b1;
                    end
                    state_d = fetch_wait ? ST_IMISS : ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output stage: flush wins over stall on a boundary, and reset silences everything.
    always_comb begin
        flush_vec = rst ? 4'b0000 : flush_raw;
        stall_vec = rst ? 3'b000  : (stall_raw & ~flush_raw[3:1]);

        pc_stall     = rst ? 1'b0 : pc_stall_raw;
        pc_redirect  = rst ? REDIR_NONE : redirect_raw;
        icache_abort = rst ? 1'b0 : abort_raw;

        stall_if_id  = stall_vec[B_IF_ID];
        stall_id_ex  = stall_vec[B_ID_EX];
        stall_ex_mem = stall_vec[B_EX_MEM];
        stall_mem_wb = 1'b0;

        flush_if_id  = flush_vec[B_IF_ID];
        flush_id_ex  = flush_vec[B_ID_EX];
        flush_ex_mem = flush_vec[B_EX_MEM];
        flush_mem_wb = flush_vec[B_MEM_WB];
    end

    // Performance counters accumulate this cycle's final outputs and wrap naturally.
    always_comb begin
        stall_cycles_d   = stall_cycles_q + {{(CNT_W-1){1'b0}}, pc_stall};
        redirect_count_d = redirect_count_q + {{(CNT_W-1){1'b0}}, (pc_redirect != REDIR_NONE)};
        stall_cycles     = stall_cycles_q;
        redirect_count   = redirect_count_q;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with fixed expected values, then a
// randomized run checked against a rule-based reference model of the controller.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_trap;
    logic        icache_miss, icache_ready, dcache_miss, dcache_ready;
    logic        pc_stall, icache_abort;
    logic [1:0]  pc_redirect;
    logic        stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [31:0] stall_cycles, redirect_count;

    // Packed view of the outputs: {pc_stall, redirect[1:0], abort, stall[4], flush[4]}
    logic [11:0] act;

    int checks = 0;
    int fails  = 0;

    // Reference model: pending data refill, pending fetch refill, one-cycle trap shadow.
    bit          m_dwait = 1'b0;
    bit          m_iwait = 1'b0;
    bit          m_trap  = 1'b0;
    logic [31:0] m_stalls = '0;
    logic [31:0] m_redirs = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_trap(mem_trap), .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .icache_abort(icache_abort),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    assign act = {pc_stall, pc_redirect, icache_abort,
                  stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

    function automatic logic [11:0] mk(input logic pc, input logic [1:0] rd, input logic ab,
                                       input logic [3:0] st, input logic [3:0] fl);
        return {pc, rd, ab, st, fl};
    endfunction

    function automatic bit model_load_use();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // Expected outputs for the current inputs, from the priority rules.
    function automatic logic [11:0] model_out();
        logic [11:0] dmiss_resp;
        dmiss_resp = mk(1'b1, 2'b00, 1'b0, 4'b1110, 4'b0001);
        if (rst)                                    return '0;
        if (m_trap)                                 return mk(1'b0, 2'b00, 1'b0, 4'b0000, 4'b1000);
        if (m_dwait)                                return dcache_ready ? 12'd0 : dmiss_resp;
        if (dcache_miss && !dcache_ready)           return dmiss_resp;
        if (mem_trap)                               return mk(1'b0, 2'b10, m_iwait, 4'b0000, 4'b1110);
        if (ex_branch_taken)                        return mk(1'b0, 2'b01, m_iwait, 4'b0000, 4'b1100);
        if (model_load_use())                       return mk(1'b1, 2'b00, 1'b0, 4'b1000, 4'b0100);
        if (m_iwait ? !icache_ready : (icache_miss && !icache_ready))
                                                    return mk(1'b1, 2'b00, 1'b0, 4'b0000, 4'b1000);
        return '0;
    endfunction

    // Advance the model across one clock edge given that cycle's expected outputs.
    function automatic void model_step(input logic [11:0] e);
        if (rst) begin
            m_dwait = 0; m_iwait = 0; m_trap = 0; m_stalls = '0; m_redirs = '0;
            return;
        end
        m_stalls = m_stalls + {31'd0, e[11]};
        m_redirs = m_redirs + {31'd0, (e[10:9] != 2'b00)};
        if (m_trap)                               m_trap = 0;
        else if (m_dwait)                         begin if (dcache_ready) m_dwait = 0; end
        else if (dcache_miss && !dcache_ready)    begin m_dwait = 1; m_iwait = 0; end
        else if (mem_trap)                        begin m_trap = 1; m_iwait = 0; end
        else if (ex_branch_taken)                 m_iwait = 0;
        else if (m_iwait)                         begin if (icache_ready) m_iwait = 0; end
        else if (icache_miss && !icache_ready)    m_iwait = 1;
    endfunction

    task automatic tick();
        logic [11:0] e;
        e = model_out();
        @(posedge clk);
        model_step(e);
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_trap = 0;
        icache_miss = 0; icache_ready = 0; dcache_miss = 0; dcache_ready = 0;
    endtask

    task automatic reset_pulse();
        rst = 1; idle(); tick(); rst = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; id_rs2 = 5'd1; id_use_rs2 = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle(); dcache_miss = 1; mem_trap = 1; ex_branch_taken = 1; icache_miss = 1; set_load_use();
        #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL reset_outputs: got %b want %b", act, 12'd0); fails++; end
        tick(); tick();
        checks++; if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, redirect_count); fails++; end
        rst = 0; idle();
    endtask

    task automatic test_load_use();
        reset_pulse();
        set_load_use(); #1;
        checks++; if (act !== mk(1, 2'b00, 0, 4'b1000, 4'b0100)) begin
            $display("[TB] FAIL load_use_bubble: got %b want %b", act, mk(1, 2'b00, 0, 4'b1000, 4'b0100)); fails++; end
        tick();
        ex_mem_read = 0; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL load_use_clear: got %b want %b", act, 12'd0); fails++; end
        checks++; if (stall_cycles !== 32'd1) begin $display("[TB] FAIL load_use_count: got %0d want 1", stall_cycles); fails++; end
        tick();
        // Load to x0 and an rs2 match that the ID instruction does not read: no hazard.
        idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL load_x0: got %b want %b", act, 12'd0); fails++; end
        tick();
        idle(); ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL load_rs2_unused: got %b want %b", act, 12'd0); fails++; end
        tick(); idle();
    endtask

    task automatic test_dmiss();
        logic [11:0] dm;
        dm = mk(1, 2'b00, 0, 4'b1110, 4'b0001);
        reset_pulse();
        for (int c = 0; c < 3; c++) begin
            dcache_miss = 1; mem_trap = (c == 1); ex_branch_taken = (c == 1); #1;
            checks++; if (act !== dm) begin $display("[TB] FAIL dmiss_cycle%0d: got %b want %b", c, act, dm); fails++; end
            tick();
        end
        idle(); dcache_ready = 1; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL dmiss_ready: got %b want %b", act, 12'd0); fails++; end
        tick();
        checks++; if (stall_cycles !== 32'd3) begin $display("[TB] FAIL dmiss_count: got %0d want 3", stall_cycles); fails++; end
        idle(); set_load_use(); #1;
        checks++; if (act !== mk(1, 2'b00, 0, 4'b1000, 4'b0100)) begin
            $display("[TB] FAIL dmiss_back_to_run: got %b want %b", act, mk(1, 2'b00, 0, 4'b1000, 4'b0100)); fails++; end
        tick();
        idle(); dcache_miss = 1; dcache_ready = 1; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL hit_after_miss: got %b want %b", act, 12'd0); fails++; end
        tick();
        idle(); #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL hit_after_miss_next: got %b want %b", act, 12'd0); fails++; end
        tick();
    endtask

    task automatic test_imiss();
        reset_pulse();
        icache_miss = 1; #1;
        checks++; if (act !== mk(1, 2'b00, 0, 4'b0000, 4'b1000)) begin
            $display("[TB] FAIL imiss_enter: got %b want %b", act, mk(1, 2'b00, 0, 4'b0000, 4'b1000)); fails++; end
        tick();
        icache_miss = 0; #1;
        checks++; if (act !== mk(1, 2'b00, 0, 4'b0000, 4'b1000)) begin
            $display("[TB] FAIL imiss_wait: got %b want %b", act, mk(1, 2'b00, 0, 4'b0000, 4'b1000)); fails++; end
        tick();
        set_load_use(); #1;
        checks++; if (act !== mk(1, 2'b00, 0, 4'b1000, 4'b0100)) begin
            $display("[TB] FAIL imiss_load_use: got %b want %b", act, mk(1, 2'b00, 0, 4'b1000, 4'b0100)); fails++; end
        tick();
        idle(); icache_ready = 1; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL imiss_ready: got %b want %b", act, 12'd0); fails++; end
        tick();
        idle(); #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL imiss_done: got %b want %b", act, 12'd0); fails++; end
        tick();
    endtask

    task automatic test_branch_in_imiss();
        reset_pulse();
        icache_miss = 1; tick();
        ex_branch_taken = 1; #1;
        checks++; if (act !== mk(0, 2'b01, 1, 4'b0000, 4'b1100)) begin
            $display("[TB] FAIL branch_imiss: got %b want %b", act, mk(0, 2'b01, 1, 4'b0000, 4'b1100)); fails++; end
        tick();
        idle(); #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL branch_imiss_run: got %b want %b", act, 12'd0); fails++; end
        checks++; if (redirect_count !== 32'd1) begin $display("[TB] FAIL branch_redirect_count: got %0d want 1", redirect_count); fails++; end
        tick();
    endtask

    task automatic test_trap();
        reset_pulse();
        mem_trap = 1; ex_branch_taken = 1; #1;
        checks++; if (act !== mk(0, 2'b10, 0, 4'b0000, 4'b1110)) begin
            $display("[TB] FAIL trap_branch: got %b want %b", act, mk(0, 2'b10, 0, 4'b0000, 4'b1110)); fails++; end
        tick();
        set_load_use(); #1;
        checks++; if (act !== mk(0, 2'b00, 0, 4'b0000, 4'b1000)) begin
            $display("[TB] FAIL trap_shadow: got %b want %b", act, mk(0, 2'b00, 0, 4'b0000, 4'b1000)); fails++; end
        tick();
        idle(); icache_miss = 1; tick();
        idle(); mem_trap = 1; #1;
        checks++; if (act !== mk(0, 2'b10, 1, 4'b0000, 4'b1110)) begin
            $display("[TB] FAIL trap_imiss: got %b want %b", act, mk(0, 2'b10, 1, 4'b0000, 4'b1110)); fails++; end
        tick();
        idle(); tick();
        #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL trap_done: got %b want %b", act, 12'd0); fails++; end
        checks++; if (redirect_count !== 32'd2) begin $display("[TB] FAIL trap_redirect_count: got %0d want 2", redirect_count); fails++; end
        tick();
    endtask

    task automatic test_reset_in_dmiss();
        reset_pulse();
        dcache_miss = 1; tick(); tick();
        rst = 1; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL rst_dmiss_outputs: got %b want %b", act, 12'd0); fails++; end
        tick();
        checks++; if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            $display("[TB] FAIL rst_dmiss_counters: got %0d/%0d want 0/0", stall_cycles, redirect_count); fails++; end
        rst = 0; dcache_miss = 0; #1;
        checks++; if (act !== 12'd0) begin $display("[TB] FAIL rst_dmiss_release: got %b want %b", act, 12'd0); fails++; end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int c = 0; c < 600; c++) begin
            rst             = ($urandom_range(0, 59) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_trap        = ($urandom_range(0, 11) == 0);
            icache_miss     = ($urandom_range(0, 4) == 0);
            icache_ready    = ($urandom_range(0, 2) == 0);
            dcache_miss     = ($urandom_range(0, 6) == 0);
            dcache_ready    = ($urandom_range(0, 2) == 0);
            #1;
            e = model_out();
            checks++; if (act !== e) begin $display("[TB] FAIL random_outputs@%0d: got %b want %b", c, act, e); fails++; end
            checks++; if (stall_cycles !== m_stalls || redirect_count !== m_redirs) begin
                $display("[TB] FAIL random_counters@%0d: got %0d/%0d want %0d/%0d", c, stall_cycles, redirect_count, m_stalls, m_redirs); fails++; end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1; idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_dmiss();
        test_imiss();
        test_branch_in_imiss();
        test_trap();
        test_reset_in_dmiss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
